// File: rtl/poly_accumulator.sv
// poly_accumulator: coefficient-wise modular accumulation of num_terms polynomials
// of N coefficients each, followed by an N-coefficient drain with a last marker.
// Optional feature macro: POLY_ACC_RANGE_CHECK_EN adds the sticky range_err output.
module poly_accumulator #(
   parameter int q    = 17,
   parameter int N    = 8,
   parameter int logq = 5,
   parameter int logN = 3,
   parameter int logT = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic [logT-1:0] num_terms,
   output logic            busy,
   input  logic            in_valid,
   input  logic [logq-1:0] in_data,
   output logic            in_ready,
   output logic            out_valid,
   output logic [logq-1:0] out_data,
   output logic            out_last,
   input  logic            out_ready
`ifdef POLY_ACC_RANGE_CHECK_EN
   ,
   output logic            range_err
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   // modulus widened by one bit so it can be compared against the raw sum
   localparam logic [logq:0] Q_EXT = q[logq:0];

   state_t          r_state;
   state_t          w_state_next;
   logic [logq-1:0] r_acc [N];
   logic [logN-1:0] r_idx;
   logic [logT-1:0] r_term;
   logic [logT-1:0] r_nterm;

   logic            w_in_hs;
   logic            w_out_hs;
   logic            w_start_acc;
   logic            w_idx_last;
   logic            w_term_last;
   logic [logq:0]   w_sum;
   logic [logq-1:0] w_acc_new;

   assign w_start_acc = (r_state == S_IDLE) && start;
   assign w_in_hs     = (r_state == S_ACCUM) && in_valid;
   assign w_out_hs    = (r_state == S_DRAIN) && out_ready;
   assign w_idx_last  = (r_idx == logN'(N - 1));
   assign w_term_last = (r_term == (r_nterm - logT'(1)));
   assign w_sum       = {1'b0, r_acc[r_idx]} + {1'b0, in_data};

   // new bank value: first term overwrites (no clear pass), later terms add mod q
   always_comb begin
      w_acc_new = in_data;
      if (r_term != '0) begin
         w_acc_new = logq'((w_sum >= Q_EXT) ? (w_sum - Q_EXT) : w_sum);
      end
   end

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // next-state logic: only start, last accumulate handshake and last drain handshake move the FSM
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_next = S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (w_in_hs && w_idx_last && w_term_last) begin
               w_state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_out_hs && w_idx_last) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // outputs decoded from state and registers only, so they hold steady during a stall
   always_comb begin
      busy      = (r_state != S_IDLE);
      in_ready  = (r_state == S_ACCUM);
      out_valid = (r_state == S_DRAIN);
      out_last  = (r_state == S_DRAIN) && w_idx_last;
      out_data  = '0;
      if (r_state == S_DRAIN) begin
         out_data = r_acc[r_idx];
      end
   end

   // coefficient/term counters and latched term count
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_idx   <= '0;
         r_term  <= '0;
         r_nterm <= logT'(1);
      end else begin
         if (w_start_acc) begin
            r_idx   <= '0;
            r_term  <= '0;
            r_nterm <= (num_terms == '0) ? logT'(1) : num_terms;
         end
         if (w_in_hs) begin
            r_idx <= r_idx + logN'(1);
            if (w_idx_last) begin
               r_term <= r_term + logT'(1);
            end
         end
         if (w_out_hs) begin
            r_idx <= r_idx + logN'(1);
         end
      end
   end

   // accumulator bank, one entry written per accepted input coefficient
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N; i++) begin
            r_acc[i] <= '0;
         end
      end else if (w_in_hs) begin
         r_acc[r_idx] <= w_acc_new;
      end
   end

`ifdef POLY_ACC_RANGE_CHECK_EN
   logic r_range_err;

   // sticky flag for any accepted coefficient outside [0, q); a new run clears it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_range_err <= 1'b0;
      end else if (w_start_acc) begin
         r_range_err <= 1'b0;
      end else if (w_in_hs && ({1'b0, in_data} >= Q_EXT)) begin
         r_range_err <= 1'b1;
      end
   end

   assign range_err = r_range_err;
`endif

endmodule

// File: tb/tb_poly_accumulator.sv
// tb_poly_accumulator: directed runs against a sum-mod-q model of the accumulator.
module tb_poly_accumulator;

   localparam int Q  = 17;
   localparam int NC = 8;

   logic       clk       = 1'b0;
   logic       reset_n   = 1'b0;
   logic       start     = 1'b0;
   logic [3:0] num_terms = 4'd0;
   logic       in_valid  = 1'b0;
   logic [4:0] in_data   = 5'd0;
   logic       out_ready = 1'b0;
   wire        busy;
   wire        in_ready;
   wire        out_valid;
   wire  [4:0] out_data;
   wire        out_last;
`ifdef POLY_ACC_RANGE_CHECK_EN
   wire        range_err;
`endif

   poly_accumulator #(.q(17), .N(8), .logq(5), .logN(3), .logT(4)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .num_terms (num_terms),
      .busy      (busy),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ready (out_ready)
`ifdef POLY_ACC_RANGE_CHECK_EN
      ,
      .range_err (range_err)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int exp_out [NC];
   int term_vals [15][NC];
   int hs_total   = 0;
   int drain_base = 0;

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, expv);
      end
   endtask

   // compare process: every drained coefficient against the model, in order
   always @(negedge clk) begin
      int k;
      if (reset_n && out_valid) begin
         k = hs_total - drain_base;
         if (k < NC) begin
            chk($sformatf("out_data[%0d]", k), int'(out_data), exp_out[k]);
            chk($sformatf("out_last[%0d]", k), int'(out_last), int'(k == NC - 1));
         end else begin
            chk("extra_out_coeff", k, NC - 1);
         end
         chk("in_ready_during_drain", int'(in_ready), 0);
         if (out_ready) hs_total++;
         $display("out k=%0d data=%0d last=%0d ready=%0d", k, out_data, out_last, out_ready);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // expected sum: plain integer addition of all terms, reduced mod q once
   task automatic model(input int nt);
      int s;
      for (int i = 0; i < NC; i++) begin
         s = 0;
         for (int t = 0; t < nt; t++) s += term_vals[t][i];
         exp_out[i] = s % Q;
      end
   endtask

   task automatic do_start(input int nt);
      start     = 1'b1;
      num_terms = nt[3:0];
      tick();
      start = 1'b0;
      chk("busy_after_start", int'(busy), 1);
   endtask

   task automatic push(input int v);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_data  = v[4:0];
      @(negedge clk);
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("push_timeout", 0, 1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic drain(input logic [3:0] pat);
      int n;
      n          = 0;
      drain_base = hs_total;
      while ((hs_total - drain_base) < NC && n < 200) begin
         out_ready = pat[n % 4];
         @(negedge clk);
         if (n == 0) chk("first_valid_latency", int'(out_valid), 1);
         tick();
         n++;
      end
      if ((hs_total - drain_base) < NC) chk("drain_timeout", hs_total - drain_base, NC);
      out_ready = 1'b0;
      @(negedge clk);
      chk("busy_after_drain", int'(busy), 0);
      chk("out_valid_after_drain", int'(out_valid), 0);
      tick();
   endtask

   task automatic run(input int nt_in, input int nt_eff, input logic [3:0] pat);
      model(nt_eff);
      do_start(nt_in);
      for (int t = 0; t < nt_eff; t++)
         for (int i = 0; i < NC; i++) push(term_vals[t][i]);
      drain(pat);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_out_data", int'(out_data), 0);
`ifdef POLY_ACC_RANGE_CHECK_EN
      chk("rst_range_err", int'(range_err), 0);
`endif
      tick();
      reset_n = 1'b1;
      tick();

      // single term 0..7 straight through
      for (int i = 0; i < NC; i++) term_vals[0][i] = i;
      run(1, 1, 4'b1111);
      chk("model_t1_c7", exp_out[7], 7);

      // two terms of 16 -> 32 mod 17 = 15; three terms 16,16,2 -> 0
      for (int i = 0; i < NC; i++) begin
         term_vals[0][i] = 16;
         term_vals[1][i] = 16;
         term_vals[2][i] = 2;
      end
      run(2, 2, 4'b1111);
      chk("model_2x16", exp_out[0], 15);
      run(3, 3, 4'b1111);
      chk("model_16_16_2", exp_out[4], 0);

      // output back-pressure 1,0,0,1 on a two-term run
      for (int i = 0; i < NC; i++) begin
         term_vals[0][i] = (3 * i + 1) % Q;
         term_vals[1][i] = 9;
      end
      run(2, 2, 4'b1001);
      chk("model_stall_c5", exp_out[5], 8);

      // start and num_terms disturbed mid-accumulate are ignored
      for (int i = 0; i < NC; i++) term_vals[0][i] = i + 9;
      model(1);
      do_start(1);
      for (int i = 0; i < 3; i++) push(term_vals[0][i]);
      start     = 1'b1;
      num_terms = 4'd3;
      push(term_vals[0][3]);
      start = 1'b0;
      for (int i = 4; i < NC; i++) push(term_vals[0][i]);
      drain(4'b1111);

      // asynchronous reset in the middle of an accumulate
      do_start(2);
      for (int i = 0; i < 4; i++) push(11);
      in_valid = 1'b1;
      reset_n  = 1'b0;
      #1;
      chk("midrst_in_ready", int'(in_ready), 0);
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_busy", int'(busy), 0);
      in_valid = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      for (int i = 0; i < NC; i++) term_vals[0][i] = 7 - i;
      run(1, 1, 4'b1111);

      // num_terms 0 acts as 1; in_valid held high in IDLE is not consumed
      in_valid = 1'b1;
      in_data  = 5'd5;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("idle_in_ready", int'(in_ready), 0);
         tick();
      end
      for (int i = 0; i < NC; i++) term_vals[0][i] = (i * 5) % Q;
      run(0, 1, 4'b1111);
      chk("model_nt0_c4", exp_out[4], 3);

`ifdef POLY_ACC_RANGE_CHECK_EN
      // out-of-range coefficient at index 3 raises the sticky flag
      for (int i = 0; i < NC; i++) term_vals[0][i] = i;
      term_vals[0][3] = 20;
      model(1);
      exp_out[3] = 20;
      do_start(1);
      for (int i = 0; i < 3; i++) push(term_vals[0][i]);
      chk("range_err_before", int'(range_err), 0);
      push(20);
      chk("range_err_set", int'(range_err), 1);
      for (int i = 4; i < NC; i++) push(term_vals[0][i]);
      drain(4'b1111);
      chk("range_err_sticky", int'(range_err), 1);
      for (int i = 0; i < NC; i++) term_vals[0][i] = 0;
      model(1);
      do_start(1);
      chk("range_err_cleared", int'(range_err), 0);
      for (int i = 0; i < NC; i++) push(0);
      drain(4'b1111);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
